// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash read sequencer.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] DUMMY   = 8'h00;

  typedef enum logic [3:0] {
    FLUSH,
    IDLE,
    SETUP,
    CMD,
    A2,
    A1,
    A0,
    DATA,
    GAP
  } state_t;

endpackage

// File: rtl/spi_flash_reader_if.sv
// Request, read-data stream and byte-engine signals of the flash reader.
interface spi_flash_reader_if #(
  parameter int LEN_W = 16
) ();

  logic             req_valid;
  logic             req_ready;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;
  logic             flash_cs_n;
  logic [7:0]       spi_tx_data;
  logic             spi_start;
  logic [7:0]       spi_rx_data;
  logic             spi_complete;

  // The reader itself.
  modport slave (
    input  req_valid, req_addr, req_len, out_ready, spi_rx_data, spi_complete,
    output req_ready, out_valid, out_data, busy, flash_cs_n, spi_tx_data, spi_start
  );

  // Requester, consumer and SPI engine seen from outside the reader.
  modport master (
    output req_valid, req_addr, req_len, out_ready, spi_rx_data, spi_complete,
    input  req_ready, out_valid, out_data, busy, flash_cs_n, spi_tx_data, spi_start
  );

endinterface

// File: rtl/spi_flash_reader.sv
// Turns (address, length) requests into 0x03 READ sequences on a byte-level SPI
// engine and streams the returned data bytes out over valid/ready.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int LEN_W        = 16,
  parameter int CS_SETUP     = 4,
  parameter int CS_GAP       = 16,
  parameter int FLUSH_CYCLES = 192
) (
  input  logic                clk100,
  input  logic                rst,
  spi_flash_reader_if.slave   bus
);

  localparam int CNT_MAX = (FLUSH_CYCLES > CS_GAP)
                         ? ((FLUSH_CYCLES > CS_SETUP) ? FLUSH_CYCLES : CS_SETUP)
                         : ((CS_GAP > CS_SETUP) ? CS_GAP : CS_SETUP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [23:0]      addr_reg;
  logic [LEN_W-1:0] rem_reg;
  logic             cs_n_reg;
  logic             start_reg;
  logic [7:0]       tx_reg;
  logic             out_valid_reg;
  logic [7:0]       out_data_reg;

  // One down-counter is shared by FLUSH, SETUP and GAP; each state reloads it
  // on entry and leaves when it reaches zero.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_reg     <= FLUSH;
      cnt_reg       <= CNT_W'(FLUSH_CYCLES - 1);
      addr_reg      <= '0;
      rem_reg       <= '0;
      cs_n_reg      <= 1'b1;
      start_reg     <= 1'b0;
      tx_reg        <= 8'h00;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        FLUSH: begin
          if (cnt_reg == '0) state_reg <= IDLE;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        IDLE: begin
          if (bus.req_valid && (bus.req_len != '0)) begin
            addr_reg  <= bus.req_addr;
            rem_reg   <= bus.req_len;
            cs_n_reg  <= 1'b0;
            cnt_reg   <= CNT_W'(CS_SETUP - 1);
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_reg == '0) begin
            state_reg <= CMD;
            start_reg <= 1'b1;
            tx_reg    <= OP_READ;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        // Each header byte's completion launches the next byte in the same cycle.
        CMD: if (bus.spi_complete) begin
          state_reg <= A2;
          start_reg <= 1'b1;
          tx_reg    <= addr_reg[23:16];
        end
        A2: if (bus.spi_complete) begin
          state_reg <= A1;
          start_reg <= 1'b1;
          tx_reg    <= addr_reg[15:8];
        end
        A1: if (bus.spi_complete) begin
          state_reg <= A0;
          start_reg <= 1'b1;
          tx_reg    <= addr_reg[7:0];
        end
        A0: if (bus.spi_complete) begin
          state_reg <= DATA;
          start_reg <= 1'b1;
          tx_reg    <= DUMMY;
        end
        DATA: begin
          // While a byte is held for the consumer the engine is idle, so the
          // bus stalls with CS low until the handshake.
          if (out_valid_reg) begin
            if (bus.out_ready) begin
              out_valid_reg <= 1'b0;
              if (rem_reg != '0) begin
                start_reg <= 1'b1;
                tx_reg    <= DUMMY;
              end else begin
                cs_n_reg  <= 1'b1;
                cnt_reg   <= CNT_W'(CS_GAP - 1);
                state_reg <= GAP;
              end
            end
          end else if (bus.spi_complete) begin
            out_data_reg  <= bus.spi_rx_data;
            out_valid_reg <= 1'b1;
            rem_reg       <= rem_reg - 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == '0) state_reg <= IDLE;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        default: state_reg <= FLUSH;
      endcase
    end
  end

  assign bus.req_ready   = (state_reg == IDLE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.flash_cs_n  = cs_n_reg;
  assign bus.spi_start   = start_reg;
  assign bus.spi_tx_data = tx_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = out_data_reg;

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
Transaction sequencer that sits directly upstream of the byte-level SPI engine. It drives the engine's start/tx_data, consumes its complete/rx_data, and owns flash chip-select. It turns a (address, length) read request into a standard 0x03 READ sequence: opcode, 24-bit address MSB first, then N data bytes. Data bytes go to the terminal's font/text loaders over a valid/ready stream.

Parameters:
LEN_W, 16, width of req_len
CS_SETUP, 4, clk100 cycles from flash_cs_n low to the first spi_start
CS_GAP, 16, minimum clk100 cycles flash_cs_n stays high between transactions
FLUSH_CYCLES, 192, cycles after reset before accepting requests (exceeds one engine byte time of 9 bits x 16 clocks)

Ports:
clk100  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  read request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  24  flash byte address
req_len  in  LEN_W  number of data bytes; 0 = no-op
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte
out_data  out  8  read byte
busy  out  1  high in any state other than IDLE
flash_cs_n  out  1  flash chip select, active low
spi_tx_data  out  8  byte to the SPI engine
spi_start  out  1  one-cycle start pulse to the SPI engine
spi_rx_data  in  8  engine receive byte, valid when spi_complete = 1
spi_complete  in  1  engine one-cycle done pulse

Behaviour:
- Reset values: flash_cs_n = 1, spi_start = 0, spi_tx_data = 0, out_valid = 0, out_data = 0, req_ready = 0, busy = 1. State = FLUSH.
- FLUSH: counts FLUSH_CYCLES, then goes to IDLE. The engine has no reset and may finish an in-flight byte. Any spi_complete seen in FLUSH or IDLE is ignored.
- IDLE: req_ready = 1, busy = 0.
  - On a handshake with req_len = 0: consume the request, stay in IDLE, no CS activity.
  - Otherwise latch addr and len, drop flash_cs_n on the next edge, and go to SETUP.
- SETUP: wait CS_SETUP cycles, then go to CMD.
- Byte issue rule, used by CMD, A2, A1, A0 and DATA:
  - Pulse spi_start for exactly one cycle with spi_tx_data stable. Hold spi_tx_data until spi_complete.
  - Never pulse start again before spi_complete. The engine silently drops starts while busy.
  - A start may be issued in the same cycle spi_complete is observed.
- Byte values: CMD sends 0x03. A2, A1 and A0 send addr[23:16], addr[15:8] and addr[7:0]. DATA sends 0x00.
- Received bytes in CMD and address states are discarded.
- DATA:
  - On spi_complete: out_data <= spi_rx_data, out_valid <= 1, remaining <= remaining - 1.
  - out_valid and out_data are held until out_ready. out_valid drops the cycle after the handshake.
  - The next dummy-byte start is issued in the handshake cycle if remaining != 0. Backpressure stalls the SPI bus with CS still low, which is legal for the flash.
  - When the handshake occurs with remaining == 0, go to GAP.
- GAP: flash_cs_n = 1 for CS_GAP cycles, then IDLE.
- Request fields are sampled only at handshake. Changes during a transaction have no effect.
- Address arithmetic belongs to the flash. The block does not increment the address; reads crossing 0xFFFFFF wrap inside the flash.
- rst mid-transaction: flash_cs_n goes high and out_valid goes low on the next edge, then FLUSH. Partial data is lost with no error flag.
- Throughput: 4 + N bytes per transaction at roughly 150 clocks per byte. Latency from request to first out_valid is about 5 byte times plus CS_SETUP.

Decomposition:
- Package spi_flash_pkg holds:
  - opcode constants: OP_READ = 8'h03, DUMMY = 8'h00
  - state enum: FLUSH, IDLE, SETUP, CMD, A2, A1, A0, DATA, GAP
- No sub-module. One shared down-counter serves FLUSH, SETUP and GAP.
- The SPI engine is instantiated beside this block at the level above, not inside it.

Test Plan:
- Bench uses the real SPI engine plus a behavioural SPI flash model with memory[i] = i[7:0] ^ 8'h5A.
- Request addr = 0x000100, len = 4, out_ready = 1 -> MOSI bytes 03 00 01 00 00 00 00 00; out_data 5A 5B 58 59; flash_cs_n low only during the transaction; then GAP of 16 cycles, then req_ready.
- Same request with out_ready held low 500 cycles after the first byte -> out_valid/out_data stable; no spi_start pulses; CS stays low; bytes resume correctly.
- len = 0 -> request consumed in 1 cycle; flash_cs_n never falls; spi_start never pulses.
- addr = 0xFFFFFE, len = 3 -> out_data from flash addresses FFFFFE, FFFFFF, 000000 (A4 A5 5A).
- Assert rst during the second address byte -> flash_cs_n high next edge; req_ready stays 0 for 192 cycles; next request of len 2 returns correct data with no dropped start.
- Back-to-back requests with req_valid held high -> flash_cs_n high for at least 16 cycles between transactions; every spi_start is exactly 1 cycle wide and never overlaps an engine byte.
